// File: rtl/attack_detector_trace_calc.sv
// attack_detector_trace_calc: single-stage trace processing for the LLC attack
// detector. Computes per-set deviation from the mean, a weighted z-score and
// fast/slow EMAs of the positive z-score, then emits an enriched record and a
// remap request. Optional feature macro: ATTACK_DETECTOR_PERSET_EMA_EN selects
// per-set EMA storage; when undefined a single global EMA pair is used.
module attack_detector_trace_calc #(
  parameter int SET_BITS   = 10,
  parameter int EMA0_SHIFT = 1,
  parameter int EMA1_SHIFT = 3,
  parameter int Z_SHIFT    = 7
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        io_tracein_valid,
  output logic        io_tracein_ready,
  input  logic [14:0] io_tracein_bits_evSum,
  input  logic [14:0] io_tracein_bits_evAvera,
  input  logic [39:0] io_tracein_bits_evSqSum,
  input  logic [29:0] io_tracein_bits_evSqAvera,
  input  logic [14:0] io_tracein_bits_evStdDev,
  input  logic [14:0] io_tracein_bits_evStdDevReci,
  input  logic [9:0]  io_tracein_bits_set,
  input  logic [14:0] io_tracein_bits_ev,
  input  logic        io_tracein_bits_detected,
  input  logic [13:0] io_tracein_bits_delta,
  output logic        io_traceout_valid,
  input  logic        io_traceout_ready,
  output logic [14:0] io_traceout_bits_evSum,
  output logic [14:0] io_traceout_bits_evAvera,
  output logic [39:0] io_traceout_bits_evSqSum,
  output logic [29:0] io_traceout_bits_evSqAvera,
  output logic [14:0] io_traceout_bits_evStdDev,
  output logic [14:0] io_traceout_bits_evStdDevReci,
  output logic [9:0]  io_traceout_bits_set,
  output logic [14:0] io_traceout_bits_ev,
  output logic [14:0] io_traceout_bits_evErrAbs,
  output logic        io_traceout_bits_evErrNeg,
  output logic [29:0] io_traceout_bits_evMulErr,
  output logic [14:0] io_traceout_bits_evWZscore,
  output logic [13:0] io_traceout_bits_delta,
  output logic        io_traceout_bits_deltaNeg,
  output logic [13:0] io_traceout_bits_emaz0,
  output logic [14:0] io_traceout_bits_emaz1,
  output logic        io_remapfire,
  output logic        io_mix
);

  localparam int NSETS = 1 << SET_BITS;

  logic        valid_q, det_q;
  logic [13:0] din_q;
  logic        in_fire_s, out_fire_s;

  // Datapath signals
  logic [14:0] avg_s, err_abs_s, wz_s, zpos_s;
  logic        err_neg_s;
  logic [29:0] mul_s, mul_sh_s;
  logic [13:0] zcap_s, old0_s, emaz0_d, delta_d;
  logic [14:0] old1_s, old1_eff_s, emaz1_d;
  logic        hist_s, delta_neg_d;
  logic signed [16:0] diff1_s, sum1_s, dif_s;
  logic signed [15:0] diff0_s, sum0_s;
  logic [16:0] dabs_s;

  assign out_fire_s       = valid_q && io_traceout_ready;
  assign io_tracein_ready = !valid_q || io_traceout_ready;
  assign in_fire_s        = io_tracein_valid && io_tracein_ready;

  // Deviation of this set from the sweep mean (mean uses evSum, not evAvera)
  assign avg_s     = io_tracein_bits_evSum >> SET_BITS;
  assign err_neg_s = io_tracein_bits_ev < avg_s;
  assign err_abs_s = err_neg_s ? (avg_s - io_tracein_bits_ev) : (io_tracein_bits_ev - avg_s);
  assign mul_s     = 30'(err_abs_s) * 30'(io_tracein_bits_evStdDevReci);
  assign mul_sh_s  = mul_s >> Z_SHIFT;
  assign wz_s      = (mul_sh_s > 30'd32767) ? 15'h7FFF : mul_sh_s[14:0];
  assign zpos_s    = err_neg_s ? 15'd0 : wz_s;
  assign zcap_s    = zpos_s[14] ? 14'h3FFF : zpos_s[13:0];

  // EMA updates; results stay in range, the upper-bit guards are for safety only
  assign diff1_s = $signed({2'b00, zpos_s}) - $signed({2'b00, old1_s});
  assign sum1_s  = $signed({2'b00, old1_s}) + (diff1_s >>> EMA1_SHIFT);
  assign diff0_s = $signed({2'b00, zcap_s}) - $signed({2'b00, old0_s});
  assign sum0_s  = $signed({2'b00, old0_s}) + (diff0_s >>> EMA0_SHIFT);

  // Select seeded (first sample) or filtered EMA values
  always_comb begin
    emaz0_d    = 14'd0;
    emaz1_d    = 15'd0;
    old1_eff_s = 15'd0;
    if (hist_s) begin
      emaz1_d    = (sum1_s[16:15] != 2'b00) ? 15'h7FFF : sum1_s[14:0];
      emaz0_d    = (sum0_s[15:14] != 2'b00) ? 14'h3FFF : sum0_s[13:0];
      old1_eff_s = old1_s;
    end else begin
      emaz1_d    = zpos_s;
      emaz0_d    = zcap_s;
      old1_eff_s = 15'd0;
    end
  end

  assign dif_s       = $signed({2'b00, emaz1_d}) - $signed({2'b00, old1_eff_s});
  assign delta_neg_d = dif_s[16];
  assign dabs_s      = dif_s[16] ? 17'(-dif_s) : 17'(dif_s);
  assign delta_d     = (dabs_s > 17'd16383) ? 14'h3FFF : dabs_s[13:0];

`ifdef ATTACK_DETECTOR_PERSET_EMA_EN
  logic [13:0]      ema0_mem [0:NSETS-1];
  logic [14:0]      ema1_mem [0:NSETS-1];
  logic [NSETS-1:0] hist_q;

  assign old0_s = ema0_mem[io_tracein_bits_set];
  assign old1_s = ema1_mem[io_tracein_bits_set];
  assign hist_s = hist_q[io_tracein_bits_set];

  // Per-set EMA storage, written on every accepted record
  always_ff @(posedge clock) begin
    if (in_fire_s) begin
      ema0_mem[io_tracein_bits_set] <= emaz0_d;
      ema1_mem[io_tracein_bits_set] <= emaz1_d;
    end
  end

  // Per-set history-valid flags; reset marks every set as unseen
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hist_q <= '0;
    end else if (in_fire_s) begin
      hist_q[io_tracein_bits_set] <= 1'b1;
    end
  end
`else
  logic [13:0] ema0_q;
  logic [14:0] ema1_q;
  logic        hist_q;

  assign old0_s = ema0_q;
  assign old1_s = ema1_q;
  assign hist_s = hist_q;

  // Global EMA pair shared by all sets
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ema0_q <= 14'd0;
      ema1_q <= 15'd0;
      hist_q <= 1'b0;
    end else if (in_fire_s) begin
      ema0_q <= emaz0_d;
      ema1_q <= emaz1_d;
      hist_q <= 1'b1;
    end
  end
`endif

  // Output record register: loads on in_fire, drains on out_fire, else holds
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid_q                       <= 1'b0;
      det_q                         <= 1'b0;
      din_q                         <= 14'd0;
      io_traceout_bits_evSum        <= 15'd0;
      io_traceout_bits_evAvera      <= 15'd0;
      io_traceout_bits_evSqSum      <= 40'd0;
      io_traceout_bits_evSqAvera    <= 30'd0;
      io_traceout_bits_evStdDev     <= 15'd0;
      io_traceout_bits_evStdDevReci <= 15'd0;
      io_traceout_bits_set          <= 10'd0;
      io_traceout_bits_ev           <= 15'd0;
      io_traceout_bits_evErrAbs     <= 15'd0;
      io_traceout_bits_evErrNeg     <= 1'b0;
      io_traceout_bits_evMulErr     <= 30'd0;
      io_traceout_bits_evWZscore    <= 15'd0;
      io_traceout_bits_delta        <= 14'd0;
      io_traceout_bits_deltaNeg     <= 1'b0;
      io_traceout_bits_emaz0        <= 14'd0;
      io_traceout_bits_emaz1        <= 15'd0;
    end else if (in_fire_s) begin
      valid_q                       <= 1'b1;
      det_q                         <= io_tracein_bits_detected;
      din_q                         <= io_tracein_bits_delta;
      io_traceout_bits_evSum        <= io_tracein_bits_evSum;
      io_traceout_bits_evAvera      <= io_tracein_bits_evAvera;
      io_traceout_bits_evSqSum      <= io_tracein_bits_evSqSum;
      io_traceout_bits_evSqAvera    <= io_tracein_bits_evSqAvera;
      io_traceout_bits_evStdDev     <= io_tracein_bits_evStdDev;
      io_traceout_bits_evStdDevReci <= io_tracein_bits_evStdDevReci;
      io_traceout_bits_set          <= io_tracein_bits_set;
      io_traceout_bits_ev           <= io_tracein_bits_ev;
      io_traceout_bits_evErrAbs     <= err_abs_s;
      io_traceout_bits_evErrNeg     <= err_neg_s;
      io_traceout_bits_evMulErr     <= mul_s;
      io_traceout_bits_evWZscore    <= wz_s;
      io_traceout_bits_delta        <= delta_d;
      io_traceout_bits_deltaNeg     <= delta_neg_d;
      io_traceout_bits_emaz0        <= emaz0_d;
      io_traceout_bits_emaz1        <= emaz1_d;
    end else if (out_fire_s) begin
      valid_q <= 1'b0;
    end else begin
      valid_q <= valid_q;
    end
  end

  assign io_traceout_valid = valid_q;
  assign io_mix            = det_q;
  // Remap request coincides with the transfer of the record that triggers it
  assign io_remapfire      = out_fire_s && (det_q || (io_traceout_bits_emaz0 > din_q));

endmodule

// File: tb/tb_attack_detector_trace_calc.sv
// Randomized self-checking bench for attack_detector_trace_calc against a
// behavioural model of the trace computation and EMA history.
module tb_attack_detector_trace_calc;

  logic        clock = 1'b0;
  logic        reset;
  logic        tin_valid, tin_ready, tout_valid, tout_ready;
  logic [14:0] i_sum, i_avera, i_std, i_reci, i_ev;
  logic [39:0] i_sq;
  logic [29:0] i_sqav;
  logic [9:0]  i_set;
  logic        i_det;
  logic [13:0] i_delta;
  logic [14:0] o_sum, o_avera, o_std, o_reci, o_ev, o_abs, o_wz, o_emaz1;
  logic [39:0] o_sq;
  logic [29:0] o_sqav, o_mul;
  logic [9:0]  o_set;
  logic        o_neg, o_dneg, remapfire, mix;
  logic [13:0] o_delta, o_emaz0;

  int checks = 0;
  int errors = 0;

  // model state
  bit     m_valid;
  longint m_sum, m_avera, m_sq, m_sqav, m_std, m_reci, m_set, m_ev;
  longint m_abs, m_neg, m_mul, m_wz, m_delta, m_dneg, m_e0, m_e1, m_det, m_din;
  int     h_e0 [1024];
  int     h_e1 [1024];
  bit     h_v  [1024];

  always #5 clock = ~clock;

  attack_detector_trace_calc dut (
    .clock(clock), .reset(reset),
    .io_tracein_valid(tin_valid), .io_tracein_ready(tin_ready),
    .io_tracein_bits_evSum(i_sum), .io_tracein_bits_evAvera(i_avera),
    .io_tracein_bits_evSqSum(i_sq), .io_tracein_bits_evSqAvera(i_sqav),
    .io_tracein_bits_evStdDev(i_std), .io_tracein_bits_evStdDevReci(i_reci),
    .io_tracein_bits_set(i_set), .io_tracein_bits_ev(i_ev),
    .io_tracein_bits_detected(i_det), .io_tracein_bits_delta(i_delta),
    .io_traceout_valid(tout_valid), .io_traceout_ready(tout_ready),
    .io_traceout_bits_evSum(o_sum), .io_traceout_bits_evAvera(o_avera),
    .io_traceout_bits_evSqSum(o_sq), .io_traceout_bits_evSqAvera(o_sqav),
    .io_traceout_bits_evStdDev(o_std), .io_traceout_bits_evStdDevReci(o_reci),
    .io_traceout_bits_set(o_set), .io_traceout_bits_ev(o_ev),
    .io_traceout_bits_evErrAbs(o_abs), .io_traceout_bits_evErrNeg(o_neg),
    .io_traceout_bits_evMulErr(o_mul), .io_traceout_bits_evWZscore(o_wz),
    .io_traceout_bits_delta(o_delta), .io_traceout_bits_deltaNeg(o_dneg),
    .io_traceout_bits_emaz0(o_emaz0), .io_traceout_bits_emaz1(o_emaz1),
    .io_remapfire(remapfire), .io_mix(mix)
  );

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // floor(a / 2^sh) for signed a
  function automatic int fdiv(input int a, input int sh);
    int d;
    d = 1 << sh;
    if (a >= 0) return a / d;
    return -((-a + d - 1) / d);
  endfunction

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic model_reset();
    m_valid = 0;
    {m_sum, m_avera, m_sq, m_sqav, m_std, m_reci, m_set, m_ev} = '0;
    {m_abs, m_neg, m_mul, m_wz, m_delta, m_dneg, m_e0, m_e1, m_det, m_din} = '0;
    for (int k = 0; k < 1024; k++) begin
      h_e0[k] = 0; h_e1[k] = 0; h_v[k] = 0;
    end
  endtask

  // Accept the record currently on the input bus into the model
  task automatic model_load();
    int avg, z, zc, idx, o1, n0, n1;
    avg = int'(i_sum) / 1024;
    m_neg = (int'(i_ev) < avg) ? 1 : 0;
    m_abs = m_neg ? (avg - int'(i_ev)) : (int'(i_ev) - avg);
    m_mul = m_abs * longint'(i_reci);
    m_wz  = (m_mul / 128 > 32767) ? 32767 : m_mul / 128;
    z  = m_neg ? 0 : int'(m_wz);
    zc = imin(z, 16383);
`ifdef ATTACK_DETECTOR_PERSET_EMA_EN
    idx = int'(i_set);
`else
    idx = 0;
`endif
    if (!h_v[idx]) begin
      o1 = 0; n1 = z; n0 = zc;
    end else begin
      o1 = h_e1[idx];
      n1 = o1 + fdiv(z - o1, 3);
      n0 = h_e0[idx] + fdiv(zc - h_e0[idx], 1);
    end
    h_e0[idx] = n0; h_e1[idx] = n1; h_v[idx] = 1;
    m_e0 = n0; m_e1 = n1;
    m_delta = imin((n1 > o1) ? n1 - o1 : o1 - n1, 16383);
    m_dneg  = (n1 < o1) ? 1 : 0;
    m_sum = i_sum; m_avera = i_avera; m_sq = i_sq; m_sqav = i_sqav;
    m_std = i_std; m_reci = i_reci; m_set = i_set; m_ev = i_ev;
    m_det = i_det; m_din = i_delta;
    m_valid = 1;
  endtask

  task automatic check_outputs();
    check_val("out_valid", tout_valid, m_valid);
    check_val("evSum", o_sum, m_sum);
    check_val("evAvera", o_avera, m_avera);
    check_val("evSqSum", o_sq, m_sq);
    check_val("evSqAvera", o_sqav, m_sqav);
    check_val("evStdDev", o_std, m_std);
    check_val("evStdDevReci", o_reci, m_reci);
    check_val("set", o_set, m_set);
    check_val("ev", o_ev, m_ev);
    check_val("evErrAbs", o_abs, m_abs);
    check_val("evErrNeg", o_neg, m_neg);
    check_val("evMulErr", o_mul, m_mul);
    check_val("evWZscore", o_wz, m_wz);
    check_val("delta", o_delta, m_delta);
    check_val("deltaNeg", o_dneg, m_dneg);
    check_val("emaz0", o_emaz0, m_e0);
    check_val("emaz1", o_emaz1, m_e1);
    check_val("mix", mix, m_det);
  endtask

  // One cycle: drive handshake, check, advance model, wait for next negedge
  task automatic step(input bit v, input bit r, output bit fired);
    bit rdy;
    tin_valid = v; tout_ready = r;
    #1;
    rdy = !m_valid || r;
    check_val("tin_ready", tin_ready, rdy);
    check_val("remapfire", remapfire, m_valid && r && (m_det != 0 || m_e0 > m_din));
    check_outputs();
    fired = v && rdy;
    if (fired) model_load();
    else if (m_valid && r) m_valid = 0;
    @(negedge clock);
  endtask

  task automatic rand_inputs(input int s);
    int avg, e;
    i_sum   = 15'($urandom_range(0, 32767));
    i_avera = 15'($urandom); i_sq = {8'($urandom), 32'($urandom)};
    i_sqav  = 30'($urandom); i_std = 15'($urandom);
    i_reci  = ($urandom_range(0, 1) == 0) ? 15'($urandom_range(0, 2047)) : 15'($urandom);
    i_set   = 10'(s);
    avg = int'(i_sum) / 1024;
    e = avg + $urandom_range(0, 40) - 20;
    if (e < 0) e = 0;
    i_ev    = ($urandom_range(0, 7) == 0) ? 15'($urandom) : 15'(e);
    i_det   = ($urandom_range(0, 7) == 0);
    i_delta = 14'($urandom);
  endtask

  initial begin
    bit f;
    int n;
    reset = 1'b0; tin_valid = 1'b0; tout_ready = 1'b0;
    rand_inputs(0);
    model_reset();
    repeat (3) @(negedge clock);
    reset = 1'b1;
    // idle after reset: everything zero, ready high
    step(0, 0, f);
    step(0, 1, f);

    // first record: set 5, avg=10, ev=18
    i_sum = 15'd10240; i_ev = 15'd18; i_reci = 15'd8192; i_set = 10'd5;
    i_det = 1'b0; i_delta = 14'd100;
    step(1, 1, f);
    check_val("ex1_abs", o_abs, 8);
    check_val("ex1_mul", o_mul, 65536);
    check_val("ex1_wz", o_wz, 512);
    check_val("ex1_emaz0", o_emaz0, 512);
    check_val("ex1_emaz1", o_emaz1, 512);
    check_val("ex1_delta", o_delta, 512);
    // stall: outputs hold, input not ready
    step(0, 0, f);
    step(0, 0, f);
    // same set, ev=10: back-to-back with the drain of the first record
    i_ev = 15'd10;
    step(1, 1, f);
    check_val("ex2_abs", o_abs, 0);
    check_val("ex2_emaz0", o_emaz0, 256);
    check_val("ex2_emaz1", o_emaz1, 448);
    check_val("ex2_delta", o_delta, 64);
    check_val("ex2_dneg", o_dneg, 1);
    // ev below mean: negative error, EMAs decay
    i_ev = 15'd2;
    step(1, 1, f);
    check_val("ex3_neg", o_neg, 1);
    check_val("ex3_abs", o_abs, 8);
    check_val("ex3_emaz0", o_emaz0, 128);
    check_val("ex3_emaz1", o_emaz1, 392);
    step(0, 1, f);

    // two full sweeps with random backpressure (wrap 1023 -> 0)
    for (int p = 0; p < 2; p++) begin
      for (int s = 0; s < 1024; s++) begin
        rand_inputs(s);
        f = 0; n = 0;
        while (!f && n < 32) begin
          step(1, $urandom_range(0, 3) != 0, f);
          n++;
        end
        if (!f) check_val("sweep_accept", 0, 1);
      end
    end

    // fully random traffic
    for (int c = 0; c < 600; c++) begin
      rand_inputs($urandom_range(0, 1023));
      step($urandom_range(0, 2) != 0, $urandom_range(0, 2) != 0, f);
    end

    // reset asserted mid-operation
    rand_inputs(7);
    step(1, 0, f);
    reset = 1'b0;
    #1;
    model_reset();
    check_val("rst_valid", tout_valid, 0);
    check_val("rst_emaz1", o_emaz1, 0);
    @(negedge clock);
    reset = 1'b1;
    step(0, 0, f);
    rand_inputs(7);
    step(1, 1, f);
    step(0, 1, f);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
